// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The IMEM_LOADER_CHECKSUM_EN build adds the CHK state to the sequence.
package mips_loader_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned WORD_W        = 8 * WORD_BYTES;

    // Byte offsets of the word-count fields within the frame header.
    localparam int unsigned CNT_HI_OFS = 0;
    localparam int unsigned CNT_LO_OFS = 1;
    localparam int unsigned HDR_BYTES  = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR,
        CHK
    } loader_state_t;

    // Left shift that places a header byte in the big-endian count field.
    function automatic int unsigned hdrShift(input int unsigned ofs);
        return 8 * (HDR_BYTES - 1 - ofs);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Big-endian word assembler: the first byte of a word ends up in the top byte.
// The first three bytes are held in registers and the fourth is taken live from byte_in.
module byte_assembler
    import mips_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    localparam int unsigned HELD_W = WORD_W - 8;
    localparam int unsigned IDX_W  = $clog2(WORD_BYTES);

    logic [HELD_W-1:0] held;
    logic [IDX_W-1:0]  byteIdx;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            held    <= '0;
            byteIdx <= '0;
        end else if (shift_en) begin
            held    <= {held[HELD_W-9:0], byte_in};
            byteIdx <= byteIdx + IDX_W'(1);
        end
    end

    // word_full means that the byte currently on byte_in completes the word.
    assign word      = {held, byte_in};
    assign word_full = (byteIdx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: it writes big-endian words to instruction memory and keeps the CPU held while loading.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_hold,
    output logic [CNT_W-1:0] words_loaded,
    output logic             done,
    output logic             error
);

    loader_state_t     state;
    logic [7:0]        cntHi;
    logic [CNT_W-1:0]  frameLen;
    logic [CNT_W-1:0]  lenNext;
    logic              xfer;
    logic              startOk;
    logic              shiftEn;
    logic              moreWords;
    logic [WORD_W-1:0] asmWord;
    logic              wordFull;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chkAcc;
`endif

    assign xfer      = byte_valid && byte_ready;
    assign startOk   = start && (state == IDLE || state == DONE || state == ERR);
    assign shiftEn   = xfer && (state == DATA);
    assign lenNext   = CNT_W'((16'(cntHi) << hdrShift(CNT_HI_OFS)) |
                              (16'(byte_data) << hdrShift(CNT_LO_OFS)));
    assign moreWords = (32'(words_loaded) + 32'd1) < 32'(frameLen);

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (startOk),
        .shift_en  (shiftEn),
        .byte_in   (byte_data),
        .word      (asmWord),
        .word_full (wordFull)
    );

    // Loader FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            byte_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b0;
            words_loaded <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cntHi        <= '0;
            frameLen     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chkAcc       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (startOk) begin
                        state        <= LEN_HI;
                        byte_ready   <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chkAcc       <= '0;
`endif
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        cntHi <= byte_data;
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        frameLen <= lenNext;
                        if (lenNext == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state      <= CHK;
`else
                            state      <= DONE;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                            byte_ready <= 1'b0;
`endif
                        end else if (32'(lenNext) > 32'(DEPTH_WORDS)) begin
                            state      <= ERR;
                            error      <= 1'b1;
                            cpu_hold   <= 1'b0;
                            byte_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        chkAcc <= chkAcc ^ byte_data;
`endif
                        if (wordFull) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_addr  <= BASE_ADDR + 32'(words_loaded) * 32'(WORD_BYTES);
                            imem_wdata <= asmWord;
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + CNT_W'(1);
                    if (moreWords) begin
                        state      <= DATA;
                        byte_ready <= 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state      <= CHK;
                        byte_ready <= 1'b1;
`else
                        state      <= DONE;
                        done       <= 1'b1;
                        cpu_hold   <= 1'b0;
                        byte_ready <= 1'b0;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                        if (byte_data == chkAcc) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

endmodule
